// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and state encoding for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int                ADDR_W   = 32;
    localparam logic [ADDR_W-1:0] PC_INC   = 32'd4;
    localparam logic [31:0]       NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module   : if_id_register
// Purpose  : IF/ID pipeline register with write enable and bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              bubble,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc_plus4_in,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid
);

    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (!reset_n || (we && bubble)) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (we) begin
            r_instr    <= instr_in;
            r_pc_plus4 <= pc_plus4_in;
            r_valid    <= 1'b1;
        end
    end

    assign instr    = r_instr;
    assign pc_plus4 = r_pc_plus4;
    assign valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC sequencing, instruction memory handshake and IF/ID loading.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]       NOP_INSTR = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              PC_write,
    input  logic              branch_taken_ID,
    input  logic [ADDR_W-1:0] branch_target_ID,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr_IF_ID,
    output logic [ADDR_W-1:0] pc_plus4_IF_ID,
    output logic              valid_IF_ID,
    output logic [4:0]        rs_IF_ID,
    output logic [4:0]        rt_IF_ID
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_hold_buf;
    logic [31:0]       w_ifid_instr;
    logic              w_ifid_we;
    logic              w_ifid_bubble;
    logic              w_buf_load;
    logic              w_req_latch;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_redirect = branch_taken_ID && PC_write;
    assign w_target   = branch_target_ID & ~32'h3;
    assign w_pc_plus4 = r_pc + PC_INC;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_hold_buf <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_req_latch) begin
                r_req_addr <= r_pc;
            end
            if (w_redirect) begin
                r_hold_buf <= '0;
            end else if (w_buf_load) begin
                r_hold_buf <= imem_data;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_ifid_we     = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_instr  = imem_data;
        w_buf_load    = 1'b0;
        w_req_latch   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    w_pc_next     = w_target;
                    w_ifid_we     = 1'b1;
                    w_ifid_bubble = 1'b1;
                    if (!imem_ready) begin
                        // Outstanding request must complete at the old address.
                        w_next_state = ST_DISCARD;
                        w_req_latch  = 1'b1;
                    end
                end else if (imem_ready && PC_write) begin
                    w_pc_next = w_pc_plus4;
                    w_ifid_we = 1'b1;
                end else if (imem_ready) begin
                    w_buf_load   = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (PC_write) begin
                    w_ifid_we     = 1'b1;
                    w_ifid_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_next     = w_target;
                    w_ifid_we     = 1'b1;
                    w_ifid_bubble = 1'b1;
                    w_next_state  = ST_FETCH;
                end else if (PC_write) begin
                    w_pc_next    = w_pc_plus4;
                    w_ifid_we    = 1'b1;
                    w_ifid_instr = r_hold_buf;
                    w_next_state = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                end
                w_ifid_we     = PC_write;
                w_ifid_bubble = 1'b1;
                if (imem_ready) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    assign imem_req  = reset_n && (r_state != ST_HOLD);
    assign imem_addr = (r_state == ST_DISCARD) ? r_req_addr : r_pc;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (w_ifid_we),
        .bubble      (w_ifid_bubble),
        .instr_in    (w_ifid_instr),
        .pc_plus4_in (w_pc_plus4),
        .instr       (instr_IF_ID),
        .pc_plus4    (pc_plus4_IF_ID),
        .valid       (valid_IF_ID)
    );

    assign rs_IF_ID = instr_IF_ID[25:21];
    assign rt_IF_ID = instr_IF_ID[20:16];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed vector bench for fetch_stage (default and wrap-around PC).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pw;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;

    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, data0, data1, instr0, instr1, pc40, pc41;
    logic [4:0]  rs0, rt0, rs1, rt1;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h8C00_0000 ^ (a << 4) ^ a ^ 32'h0025_0000;
    endfunction

    assign data0 = mem(addr0);
    assign data1 = mem(addr1);

    fetch_stage dut0 (
        .clk(clk), .reset_n(reset_n), .PC_write(pw), .branch_taken_ID(br),
        .branch_target_ID(tgt), .imem_req(req0), .imem_addr(addr0),
        .imem_ready(rdy), .imem_data(data0), .instr_IF_ID(instr0),
        .pc_plus4_IF_ID(pc40), .valid_IF_ID(valid0), .rs_IF_ID(rs0), .rt_IF_ID(rt0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset_n(reset_n), .PC_write(pw), .branch_taken_ID(br),
        .branch_target_ID(tgt), .imem_req(req1), .imem_addr(addr1),
        .imem_ready(rdy), .imem_data(data1), .instr_IF_ID(instr1),
        .pc_plus4_IF_ID(pc41), .valid_IF_ID(valid1), .rs_IF_ID(rs1), .rt_IF_ID(rt1)
    );

    typedef struct {
        logic        pw;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mkv(input int p, input int b, input logic [31:0] t, input int r,
                                 input logic [31:0] ea, input int er, input logic [31:0] ei,
                                 input logic [31:0] ep, input int ev);
        vec_t v;
        v.pw = (p != 0);  v.br = (b != 0);  v.tgt = t;  v.rdy = (r != 0);
        v.e_addr = ea;  v.e_req = (er != 0);  v.e_instr = ei;  v.e_pc4 = ep;
        v.e_valid = (ev != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pw br tgt rdy | addr req | instr pc+4 valid (after the edge)
        vecs[0]  = mkv(1, 0, 32'h0,   1, 32'h00,  1, mem(32'h00),  32'h04,  1);
        vecs[1]  = mkv(1, 0, 32'h0,   1, 32'h04,  1, mem(32'h04),  32'h08,  1);
        vecs[2]  = mkv(0, 0, 32'h0,   1, 32'h08,  1, mem(32'h04),  32'h08,  1);
        vecs[3]  = mkv(0, 0, 32'h0,   1, 32'h08,  0, mem(32'h04),  32'h08,  1);
        vecs[4]  = mkv(1, 0, 32'h0,   0, 32'h08,  0, mem(32'h08),  32'h0C,  1);
        vecs[5]  = mkv(1, 0, 32'h0,   1, 32'h0C,  1, mem(32'h0C),  32'h10,  1);
        vecs[6]  = mkv(1, 1, 32'h40,  1, 32'h10,  1, 32'h0,        32'h0,   0);
        vecs[7]  = mkv(1, 0, 32'h0,   1, 32'h40,  1, mem(32'h40),  32'h44,  1);
        vecs[8]  = mkv(0, 1, 32'h100, 1, 32'h44,  1, mem(32'h40),  32'h44,  1);
        vecs[9]  = mkv(1, 0, 32'h0,   0, 32'h44,  0, mem(32'h44),  32'h48,  1);
        vecs[10] = mkv(1, 1, 32'h83,  1, 32'h48,  1, 32'h0,        32'h0,   0);
        vecs[11] = mkv(1, 0, 32'h0,   0, 32'h80,  1, 32'h0,        32'h0,   0);
        vecs[12] = mkv(0, 0, 32'h0,   0, 32'h80,  1, 32'h0,        32'h0,   0);
        vecs[13] = mkv(1, 0, 32'h0,   1, 32'h80,  1, mem(32'h80),  32'h84,  1);
        vecs[14] = mkv(1, 1, 32'h200, 0, 32'h84,  1, 32'h0,        32'h0,   0);
        vecs[15] = mkv(1, 0, 32'h0,   0, 32'h84,  1, 32'h0,        32'h0,   0);
        vecs[16] = mkv(1, 0, 32'h0,   1, 32'h84,  1, 32'h0,        32'h0,   0);
        vecs[17] = mkv(1, 0, 32'h0,   1, 32'h200, 1, mem(32'h200), 32'h204, 1);

        reset_n = 1'b0; pw = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b1;
        tick();
        tick();
        chk("rst_req",   {31'b0, req0},   32'h0);
        chk("rst_addr",  addr0,           32'h0);
        chk("rst_instr", instr0,          32'h0);
        chk("rst_pc4",   pc40,            32'h0);
        chk("rst_valid", {31'b0, valid0}, 32'h0);
        chk("rst_addr1", addr1,           32'hFFFF_FFFC);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            pw = vecs[i].pw; br = vecs[i].br; tgt = vecs[i].tgt; rdy = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_addr", i), addr0, vecs[i].e_addr);
            chk($sformatf("v%0d_req", i), {31'b0, req0}, {31'b0, vecs[i].e_req});
            tick();
            chk($sformatf("v%0d_instr", i), instr0, vecs[i].e_instr);
            chk($sformatf("v%0d_pc4", i), pc40, vecs[i].e_pc4);
            chk($sformatf("v%0d_valid", i), {31'b0, valid0}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_rs_rt", i), {22'b0, rs0, rt0},
                {22'b0, vecs[i].e_instr[25:21], vecs[i].e_instr[20:16]});
        end

        // Wrap-around instance: fetch at 0xFFFFFFFC, redirect into DISCARD, reset there.
        reset_n = 1'b0; pw = 1'b1; br = 1'b0; rdy = 1'b1;
        #1;
        chk("rst_req_low0", {31'b0, req0}, 32'h0);
        chk("rst_req_low1", {31'b0, req1}, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("w_addr_top", addr1, 32'hFFFF_FFFC);
        chk("w_req",      {31'b0, req1}, 32'h1);
        tick();
        chk("w_instr", instr1, mem(32'hFFFF_FFFC));
        chk("w_pc4",   pc41,   32'h0);
        chk("w_addr0", addr1,  32'h0);

        br = 1'b1; tgt = 32'h300; rdy = 1'b0;
        tick();
        chk("d_valid", {31'b0, valid1}, 32'h0);
        chk("d_addr_stable", addr1, 32'h0);
        tgt = 32'h400;
        tick();
        chk("d_addr_stable2", addr1, 32'h0);
        chk("d_req", {31'b0, req1}, 32'h1);

        reset_n = 1'b0; br = 1'b0; rdy = 1'b1;
        #1;
        chk("d_rst_req", {31'b0, req1}, 32'h0);
        tick();
        chk("d_rst_addr",  addr1, 32'hFFFF_FFFC);
        chk("d_rst_instr", instr1, 32'h0);
        chk("d_rst_pc4",   pc41, 32'h0);
        chk("d_rst_valid", {31'b0, valid1}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("a_addr", addr1, 32'hFFFF_FFFC);
        tick();
        chk("a_instr", instr1, mem(32'hFFFF_FFFC));
        chk("a_valid", {31'b0, valid1}, 32'h1);
        chk("a_addr_wrap", addr1, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
